elastic_pipe_reg: RTL and testbench



---
 rtl/mips_core_pkg.sv | 55 +++++
 rtl/elastic_pipe_mem.sv | 28 ++
 rtl/elastic_pipe_reg.sv | 99 +++++++++
 tb/tb_elastic_pipe_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared MIPS core definitions: inter-stage payload structs, hazard flush reasons
// and small sizing helpers used by the elastic pipeline stage.
package mips_core_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALUOP_W  = 4;

  // Why hazard control requested a pipeline flush.
  typedef enum logic [2:0] {
    FLUSH_NONE,
    FLUSH_BRANCH,
    FLUSH_JUMP,
    FLUSH_EXCEPTION,
    FLUSH_ERET
  } flushReason_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } i2d_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rsVal;
    logic [XLEN-1:0]    rtVal;
    logic [XLEN-1:0]    imm;
    logic [REG_AW-1:0]  rd;
    logic [ALUOP_W-1:0] aluOp;
    logic               memRead;
    logic               memWrite;
    logic               regWrite;
  } d2e_t;

  typedef struct packed {
    logic [XLEN-1:0]   aluResult;
    logic [XLEN-1:0]   storeData;
    logic [REG_AW-1:0] rd;
    logic              memRead;
    logic              memWrite;
    logic              regWrite;
  } e2m_t;

  typedef struct packed {
    logic [XLEN-1:0]   wbData;
    logic [REG_AW-1:0] rd;
    logic              regWrite;
  } m2w_t;

  // Index width for an n-entry array; a single entry still needs one bit.
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elastic_pipe_mem.sv
// Payload storage for elastic_pipe_reg: DEPTH x DATA_W registers,
// one synchronous write port and one asynchronous read port, never reset.
module elastic_pipe_mem
  import mips_core_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned AW     = idxWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic ready/valid pipeline stage with bubble squashing and synchronous flush.
// Optional ELASTIC_PIPE_STATS_EN adds a saturating downstream-stall counter.
module elastic_pipe_reg
  import mips_core_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [DATA_W-1:0]          o_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ELASTIC_PIPE_STATS_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  localparam int unsigned PW = idxWidth(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  assign i_ready = ~flush & (r_count < FULL_COUNT);
  assign o_valid = (r_count != '0);
  assign w_push  = i_valid & i_ready;
  assign w_pop   = o_valid & o_ready;
  assign count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  elastic_pipe_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wrPtr),
    .i_wdata (i_data),
    .i_raddr (r_rdPtr),
    .o_rdata (o_data)
  );

`ifdef ELASTIC_PIPE_STATS_EN
  logic [31:0] r_stallCycles;

  // Survives flush on purpose so hazard-induced flushes don't hide backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= '0;
    end else if (o_valid && !o_ready && (r_stallCycles != 32'hFFFF_FFFF)) begin
      r_stallCycles <= r_stallCycles + 32'd1;
    end
  end

  assign stall_cycles = r_stallCycles;
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Self-checking bench for elastic_pipe_reg: a DEPTH=2 and a DEPTH=3 instance,
// each shadowed by a scoreboard queue that predicts occupancy, handshakes and data.
module tb_elastic_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        v2, r2, f2;
  logic [31:0] d2;
  logic        ir2, ov2;
  logic [31:0] od2;
  logic [1:0]  cnt2;

  logic        v3, r3, f3;
  logic [31:0] d3;
  logic        ir3, ov3;
  logic [31:0] od3;
  logic [1:0]  cnt3;

`ifdef ELASTIC_PIPE_STATS_EN
  logic [31:0] st2, st3;
`endif

  int          passCount  = 0;
  int          checkCount = 0;
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [31:0] stallModel = 32'd0;
  logic        doPush2, doPop2, doPush3, doPop3;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.DATA_W(32), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(v2), .i_ready(ir2), .i_data(d2),
    .o_valid(ov2), .o_ready(r2), .o_data(od2),
    .flush(f2), .count(cnt2)
`ifdef ELASTIC_PIPE_STATS_EN
    , .stall_cycles(st2)
`endif
  );

  elastic_pipe_reg #(.DATA_W(32), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(v3), .i_ready(ir3), .i_data(d3),
    .o_valid(ov3), .o_ready(r3), .o_data(od3),
    .flush(f3), .count(cnt3)
`ifdef ELASTIC_PIPE_STATS_EN
    , .stall_cycles(st3)
`endif
  );

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drives one cycle of inputs to the selected unit, shortly after the rising edge;
  // the other unit idles with o_ready high so it drains.
  task automatic applyStimulus(input int unit, input logic v, input logic [31:0] d,
                               input logic rdy, input logic fl);
    @(posedge clk);
    #2;
    if (unit == 2) begin
      v2 = v; d2 = d; r2 = rdy; f2 = fl;
      v3 = 1'b0; d3 = 32'd0; r3 = 1'b1; f3 = 1'b0;
    end else begin
      v3 = v; d3 = d; r3 = rdy; f3 = fl;
      v2 = 1'b0; d2 = 32'd0; r2 = 1'b1; f2 = 1'b0;
    end
  endtask

  // Scoreboard for the DEPTH=2 unit, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      q2.delete();
    end else begin
      checkOutput("count2", {30'd0, cnt2}, q2.size());
      checkOutput("oValid2", {31'd0, ov2}, {31'd0, q2.size() != 0});
      checkOutput("iReady2", {31'd0, ir2}, {31'd0, !f2 && (q2.size() < 2)});
      doPop2  = (q2.size() != 0) && r2;
      doPush2 = v2 && !f2 && (q2.size() < 2);
      if (doPop2) checkOutput("data2", od2, q2.pop_front());
      if (f2) q2.delete();
      if (doPush2) q2.push_back(d2);
    end
  end

  // Scoreboard for the DEPTH=3 unit, including the stall counter model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q3.delete();
      stallModel = 32'd0;
    end else begin
      checkOutput("count3", {30'd0, cnt3}, q3.size());
      checkOutput("oValid3", {31'd0, ov3}, {31'd0, q3.size() != 0});
      checkOutput("iReady3", {31'd0, ir3}, {31'd0, !f3 && (q3.size() < 3)});
`ifdef ELASTIC_PIPE_STATS_EN
      checkOutput("stall3", st3, stallModel);
`endif
      if ((q3.size() != 0) && !r3 && (stallModel != 32'hFFFF_FFFF)) stallModel++;
      doPop3  = (q3.size() != 0) && r3;
      doPush3 = v3 && !f3 && (q3.size() < 3);
      if (doPop3) checkOutput("data3", od3, q3.pop_front());
      if (f3) q3.delete();
      if (doPush3) q3.push_back(d3);
    end
  end

  initial begin
    rst_n = 1'b0;
    v2 = 1'b0; d2 = 32'd0; r2 = 1'b0; f2 = 1'b0;
    v3 = 1'b0; d3 = 32'd0; r3 = 1'b0; f3 = 1'b0;

    #11;
    checkOutput("rstCount2", {30'd0, cnt2}, 32'd0);
    checkOutput("rstOValid2", {31'd0, ov2}, 32'd0);
    checkOutput("rstIReady2", {31'd0, ir2}, 32'd1);
    checkOutput("rstCount3", {30'd0, cnt3}, 32'd0);
`ifdef ELASTIC_PIPE_STATS_EN
    checkOutput("rstStall2", st2, 32'd0);
    checkOutput("rstStall3", st3, 32'd0);
`endif
    #1 rst_n = 1'b1;
    $display("[TB] reset released");

    // Streaming through DEPTH=2 at full rate.
    for (int i = 1; i <= 8; i++) applyStimulus(2, 1'b1, 32'(i), 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("streamLastCount", {30'd0, cnt2}, 32'd1);
    applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b0);

    // DEPTH=3 fills, backpressures and holds 0xD upstream.
    applyStimulus(3, 1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(3, 1'b1, 32'hB, 1'b0, 1'b0);
    applyStimulus(3, 1'b1, 32'hC, 1'b0, 1'b0);
    applyStimulus(3, 1'b1, 32'hD, 1'b0, 1'b0);
    #1;
    checkOutput("fullIReady3", {31'd0, ir3}, 32'd0);
    checkOutput("fullCount3", {30'd0, cnt3}, 32'd3);
    applyStimulus(3, 1'b1, 32'hD, 1'b0, 1'b0);
    applyStimulus(3, 1'b1, 32'hD, 1'b1, 1'b0);
    applyStimulus(3, 1'b1, 32'hD, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b0);

    // Bubbles between valid beats are not stored.
    for (int i = 0; i < 6; i++)
      applyStimulus(3, (i % 2) == 0, 32'h10 + 32'(i / 2), 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b0);
    #1 checkOutput("bubbleCount3", {30'd0, cnt3}, 32'd3);
    for (int i = 0; i < 4; i++) applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b0);

    // Flush of a full DEPTH=2 stage with a push offered in the same cycle.
    applyStimulus(2, 1'b1, 32'h20, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 32'h21, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 32'h22, 1'b0, 1'b1);
    #1 checkOutput("flushIReady2", {31'd0, ir2}, 32'd0);
    applyStimulus(2, 1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("postFlushCount2", {30'd0, cnt2}, 32'd0);
    checkOutput("postFlushOValid2", {31'd0, ov2}, 32'd0);
    applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset between edges while two entries are held.
    applyStimulus(2, 1'b1, 32'h30, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 32'h31, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 32'd0, 1'b0, 1'b0);
    #1 checkOutput("preRstCount2", {30'd0, cnt2}, 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstOValid2", {31'd0, ov2}, 32'd0);
    checkOutput("asyncRstCount2", {30'd0, cnt2}, 32'd0);
    checkOutput("asyncRstIReady2", {31'd0, ir2}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Five stalled cycles, then a flush that also pops; the counter keeps 5.
    applyStimulus(3, 1'b1, 32'h40, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(3, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b0);
    #1;
    checkOutput("postFlushCount3", {30'd0, cnt3}, 32'd0);
`ifdef ELASTIC_PIPE_STATS_EN
    checkOutput("stallAfterFlush", st3, 32'd5);
`endif
    applyStimulus(3, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 32'd0, 1'b1, 1'b0);
    @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
